// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_tx
// Description : Parallel-to-serial word transmitter, MSB first, each bit held
//               BIT_CYCLES clocks with a mid-bit Strobe. Optional even-parity
//               bit enabled by defining SER_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Load,
    output logic             Ready,
    output logic             Do,
    output logic             Strobe,
    output logic             Busy,
    output logic             Done
);

    localparam int c_cw = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int c_bw = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_cw-1:0] c_cyc_last  = c_cw'(BIT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cyc_mid   = c_cw'(BIT_CYCLES / 2);
    localparam logic [c_bw-1:0] c_bit_first = c_bw'(WIDTH - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_cycle;
    logic [c_cw-1:0]   w_cycle_next;
    logic [c_bw-1:0]   r_bit;
    logic [c_bw-1:0]   w_bit_next;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  w_shift_next;
    logic              w_done_next;
    logic              w_do_next;
    logic              w_strobe_next;
    logic              w_busy_next;
    logic              w_accept;
    logic              r_do;
    logic              r_strobe;
    logic              r_busy;
    logic              r_done;
`ifdef SER_TX_PARITY_EN
    logic              r_par;
    logic              w_par_next;
`endif

    assign w_accept = Load & ~r_busy;

    // Next-state and next-register logic; outputs are registered from the
    // next-state values so they line up with the state they describe.
    always_comb begin
        w_state_next = r_state;
        w_cycle_next = r_cycle;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_done_next  = 1'b0;
`ifdef SER_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                    w_shift_next = Data;
                    w_bit_next   = c_bit_first;
                    w_cycle_next = '0;
`ifdef SER_TX_PARITY_EN
                    w_par_next   = ^Data;
`endif
                end
            end
            ST_SHIFT: begin
                if (r_cycle == c_cyc_last) begin
                    w_cycle_next = '0;
                    w_shift_next = r_shift << 1;
                    if (r_bit == '0) begin
`ifdef SER_TX_PARITY_EN
                        w_state_next = ST_PAR;
`else
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
`endif
                    end else begin
                        w_bit_next = r_bit - c_bw'(1);
                    end
                end else begin
                    w_cycle_next = r_cycle + c_cw'(1);
                end
            end
`ifdef SER_TX_PARITY_EN
            ST_PAR: begin
                if (r_cycle == c_cyc_last) begin
                    w_cycle_next = '0;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cycle_next = r_cycle + c_cw'(1);
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
                w_cycle_next = '0;
                w_bit_next   = '0;
                w_shift_next = '0;
            end
        endcase
    end

    always_comb begin
        w_do_next     = 1'b0;
        w_busy_next   = (w_state_next != ST_IDLE);
        w_strobe_next = w_busy_next && (w_cycle_next == c_cyc_mid);
        if (w_state_next == ST_SHIFT) begin
            w_do_next = w_shift_next[WIDTH-1];
        end
`ifdef SER_TX_PARITY_EN
        if (w_state_next == ST_PAR) begin
            w_do_next = w_par_next;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_cycle  <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_do     <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SER_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_cycle  <= w_cycle_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_do     <= w_do_next;
            r_strobe <= w_strobe_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
`ifdef SER_TX_PARITY_EN
            r_par    <= w_par_next;
`endif
        end
    end

    assign Ready  = ~r_busy;
    assign Do     = r_do;
    assign Strobe = r_strobe;
    assign Busy   = r_busy;
    assign Done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// Testbench for serial_word_tx (WIDTH=8, BIT_CYCLES=4): table-driven words plus
// hand-written reset, busy-load, back-to-back and mid-word-reset sequences.
module tb_serial_word_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       load;
    logic       ready;
    logic       dout;
    logic       strobe;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

`ifdef SER_TX_PARITY_EN
    localparam int NCYC = 36;
`else
    localparam int NCYC = 32;
`endif

    serial_word_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut (
        .Clk    (clk),
        .Reset  (rst),
        .Data   (data),
        .Load   (load),
        .Ready  (ready),
        .Do     (dout),
        .Strobe (strobe),
        .Busy   (busy),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;      // expected serial order, leftmost first
        logic       par;
        int         busy_cyc;  // cycle to inject a Load while busy (0 = none)
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered while observing cycle 1 of a word; leaves while observing the Done cycle.
    task automatic run_word(input logic [7:0] bits, input logic par, input int busy_cyc);
        int k;
        logic exp_do;
        for (int c = 1; c <= NCYC; c++) begin
            k = (c - 1) / 4;
            exp_do = (k < 8) ? bits[7 - k] : par;
            chk($sformatf("do c%0d", c), {31'b0, dout}, {31'b0, exp_do});
            chk($sformatf("strobe c%0d", c), {31'b0, strobe}, {31'b0, ((c - 1) % 4) == 2});
            chk($sformatf("busy c%0d", c), {31'b0, busy}, 32'd1);
            chk($sformatf("ready c%0d", c), {31'b0, ready}, 32'd0);
            chk($sformatf("done c%0d", c), {31'b0, done}, 32'd0);
            if (busy_cyc != 0 && c == busy_cyc) begin
                load = 1'b1;
                data = 8'hFF;
            end
            if (busy_cyc != 0 && c == busy_cyc + 1) load = 1'b0;
            step();
        end
        chk("done pulse", {31'b0, done}, 32'd1);
        chk("busy end", {31'b0, busy}, 32'd0);
        chk("ready end", {31'b0, ready}, 32'd1);
        chk("do end", {31'b0, dout}, 32'd0);
        chk("strobe end", {31'b0, strobe}, 32'd0);
    endtask

    task automatic accept(input logic [7:0] d);
        data = d;
        load = 1'b1;
        step();
        load = 1'b0;
        data = ~d;
    endtask

    initial begin
        logic seen_done;

        vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0, 0};
        vecs[1] = '{8'h3C, 8'b0011_1100, 1'b0, 10};
        vecs[2] = '{8'h07, 8'b0000_0111, 1'b1, 0};
        vecs[3] = '{8'h80, 8'b1000_0000, 1'b1, 0};
        vecs[4] = '{8'h01, 8'b0000_0001, 1'b1, 0};
        vecs[5] = '{8'hFF, 8'b1111_1111, 1'b0, 0};

        rst  = 1'b1;
        load = 1'b1;
        data = 8'hFF;
        step();
        step();
        chk("rst do", {31'b0, dout}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst ready", {31'b0, ready}, 32'd1);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst strobe", {31'b0, strobe}, 32'd0);
        rst  = 1'b0;
        load = 1'b0;
        step();
        chk("post rst idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].data);
            run_word(vecs[i].bits, vecs[i].par, vecs[i].busy_cyc);
            step();
            chk($sformatf("idle after v%0d", i), {31'b0, busy}, 32'd0);
            chk($sformatf("done clr v%0d", i), {31'b0, done}, 32'd0);
        end

        // Back-to-back: Load held high across the first word's Done cycle.
        data = 8'h81;
        load = 1'b1;
        step();
        data = 8'h7E;
        run_word(8'b1000_0001, 1'b0, 0);
        step();
        load = 1'b0;
        data = 8'h00;
        run_word(8'b0111_1110, 1'b0, 0);
        step();
        chk("b2b idle", {31'b0, busy}, 32'd0);

        // Reset in cycle 14 of an 8'hFF word.
        accept(8'hFF);
        for (int c = 1; c < 14; c++) step();
        chk("pre-abort do", {31'b0, dout}, 32'd1);
        rst  = 1'b1;
        load = 1'b1;
        step();
        rst  = 1'b0;
        load = 1'b0;
        chk("abort do", {31'b0, dout}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort ready", {31'b0, ready}, 32'd1);
        seen_done = done;
        for (int c = 0; c < 30; c++) begin
            step();
            seen_done |= done | busy;
        end
        chk("abort no done", {31'b0, seen_done}, 32'd0);
        accept(8'hA5);
        run_word(8'b1010_0101, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
